// File: rtl/rhd_pkg.sv
// Shared constants for the RHD2132 SPI responder: opcodes, special command words,
// register-map indices and the decoded command layout.
package rhd_pkg;

    localparam logic [1:0] OP_CONVERT = 2'b00;
    localparam logic [1:0] OP_SPECIAL = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    localparam logic [15:0] CMD_CALIBRATE = 16'h5500;
    localparam logic [15:0] CMD_CLEAR     = 16'h6A00;

    localparam logic [4:0] FRAME_BITS = 5'd16;
    localparam logic [5:0] WR_REG_MAX = 6'd17;
    localparam int         N_WR_REGS  = 18;

    localparam logic [5:0] REG_INTAN_FIRST = 6'd40;
    localparam logic [5:0] REG_INTAN_LAST  = 6'd44;
    localparam logic [5:0] REG_DIE_REV     = 6'd60;
    localparam logic [5:0] REG_UNIPOLAR    = 6'd61;
    localparam logic [5:0] REG_N_AMPS      = 6'd62;
    localparam logic [5:0] REG_CHIP_ID     = 6'd63;

    localparam logic [7:0] ASCII_I = 8'd73;
    localparam logic [7:0] ASCII_N = 8'd78;
    localparam logic [7:0] ASCII_T = 8'd84;
    localparam logic [7:0] ASCII_A = 8'd65;

    typedef struct packed {
        logic [1:0] op;
        logic [5:0] addr;
        logic [7:0] data;
    } rhd_cmd_t;

    // Company-name bytes "INTAN" occupy registers 40..44 in order.
    function automatic logic [7:0] intan_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = ASCII_I;
            3'd1:    b = ASCII_N;
            3'd2:    b = ASCII_T;
            3'd3:    b = ASCII_A;
            3'd4:    b = ASCII_N;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rhd_spi_edge_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin with single-cycle rise/fall
// pulses derived from one extra edge-detect flop.
module rhd_spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sysclk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= level;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/rhd_spi_responder.sv
// RHD2132 SPI responder with 64x8 register map and two-frame response pipeline.
// Define RHD_RESP_CONVERT_PATTERN_EN to return {channel, conversion count} for CONVERT.
module rhd_spi_responder
    import rhd_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CHIP_ID     = 8'd1,
    parameter logic [7:0] N_AMPS      = 8'd32,
    parameter logic [7:0] DIE_REV     = 8'd0
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        rhd_cs,
    input  logic        rhd_sck,
    input  logic        rhd_mosi,
    output logic        rhd_miso,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] last_cmd
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_DECODE = 2'd2;

    logic cs_rise, cs_fall, sck_rise, sck_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    logic [1:0]  state_q;
    logic [4:0]  bit_cnt_q;
    logic [15:0] rx_q;
    logic [15:0] tx_q;
    logic [15:0] resp_new_q;
    logic [15:0] resp_old_q;
    logic [7:0]  regs_q [N_WR_REGS];

    rhd_cmd_t    cmd;
    logic [7:0]  rd_data;
    logic [15:0] resp;
    logic        frame_ok;

`ifdef RHD_RESP_CONVERT_PATTERN_EN
    logic [9:0] conv_cnt_q;
`endif

    rhd_spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .sysclk (sysclk),
        .rst    (rst),
        .din    (rhd_cs),
        .rise   (cs_rise),
        .fall   (cs_fall)
    );

    rhd_spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .sysclk (sysclk),
        .rst    (rst),
        .din    (rhd_sck),
        .rise   (sck_rise),
        .fall   (sck_fall)
    );

    // MOSI has the same depth as the SCLK level path so the sampled bit lines up with sck_rise.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], rhd_mosi};
        end
    end

    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign cmd      = rx_q;
    assign frame_ok = (bit_cnt_q == FRAME_BITS);

    always_comb begin
        rd_data = 8'h00;
        if (cmd.addr <= WR_REG_MAX) begin
            rd_data = regs_q[cmd.addr[4:0]];
        end else if (cmd.addr >= REG_INTAN_FIRST && cmd.addr <= REG_INTAN_LAST) begin
            rd_data = intan_byte(3'(cmd.addr - REG_INTAN_FIRST));
        end else if (cmd.addr == REG_DIE_REV) begin
            rd_data = DIE_REV;
        end else if (cmd.addr == REG_UNIPOLAR) begin
            rd_data = 8'd1;
        end else if (cmd.addr == REG_N_AMPS) begin
            rd_data = N_AMPS;
        end else if (cmd.addr == REG_CHIP_ID) begin
            rd_data = CHIP_ID;
        end
    end

    always_comb begin
        resp = 16'h0000;
        case (cmd.op)
            OP_READ:    resp = {8'h00, rd_data};
            OP_WRITE:   resp = {8'hFF, cmd.data};
`ifdef RHD_RESP_CONVERT_PATTERN_EN
            OP_CONVERT: resp = {cmd.addr, conv_cnt_q};
`else
            OP_CONVERT: resp = 16'h8000;
`endif
            // CALIBRATE, CLEAR and every other 01 code answer with zero.
            OP_SPECIAL: resp = 16'h0000;
            default:    resp = 16'h0000;
        endcase
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            rhd_miso   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            last_cmd   <= '0;
            resp_new_q <= '0;
            resp_old_q <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_q   <= ST_SHIFT;
                        bit_cnt_q <= '0;
                        rx_q      <= '0;
                        tx_q      <= resp_old_q;
                        rhd_miso  <= resp_old_q[15];
                    end
                end
                ST_SHIFT: begin
                    if (sck_rise) begin
                        rx_q <= {rx_q[14:0], mosi_s};
                        if (bit_cnt_q != 5'd31) begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                    if (sck_fall) begin
                        tx_q     <= {tx_q[14:0], 1'b0};
                        rhd_miso <= tx_q[14];
                    end
                    // An SCLK edge in the same cycle as CS rise is applied above before decode.
                    if (cs_rise) begin
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_q <= ST_IDLE;
                    if (frame_ok) begin
                        frame_done <= 1'b1;
                        last_cmd   <= rx_q;
                        resp_old_q <= resp_new_q;
                        resp_new_q <= resp;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_WR_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (state_q == ST_DECODE && frame_ok && cmd.op == OP_WRITE
                     && cmd.addr <= WR_REG_MAX) begin
            regs_q[cmd.addr[4:0]] <= cmd.data;
        end
    end

`ifdef RHD_RESP_CONVERT_PATTERN_EN
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            conv_cnt_q <= '0;
        end else if (state_q == ST_DECODE && frame_ok && cmd.op == OP_CONVERT) begin
            conv_cnt_q <= conv_cnt_q + 10'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rhd_spi_responder.sv
// Self-checking bench for rhd_spi_responder: SPI master driver, reference register-map
// model and a two-deep expected-response queue mirroring the chip's frame latency.
module tb_rhd_spi_responder;
    import rhd_pkg::*;

    localparam int H = 40;

    logic        sysclk = 1'b0;
    logic        rst;
    logic        rhd_cs;
    logic        rhd_sck;
    logic        rhd_mosi;
    logic        rhd_miso;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] last_cmd;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int n_valid  = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  m_regs [18];
    logic [9:0]  m_conv;

    rhd_spi_responder dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .rhd_cs     (rhd_cs),
        .rhd_sck    (rhd_sck),
        .rhd_mosi   (rhd_mosi),
        .rhd_miso   (rhd_miso),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .last_cmd   (last_cmd)
    );

    // clock / reset
    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic model_reset();
        exp_q = '{16'h0000, 16'h0000};
        for (int i = 0; i < 18; i++) m_regs[i] = 8'h00;
        m_conv = '0;
    endtask

    function automatic logic [15:0] model_resp(input logic [15:0] c);
        logic [5:0]  a;
        logic [7:0]  v;
        logic [15:0] r;
        a = c[13:8];
        r = 16'h0000;
        case (c[15:14])
            2'b11: begin
                case (a)
                    6'd40: v = 8'd73;
                    6'd41: v = 8'd78;
                    6'd42: v = 8'd84;
                    6'd43: v = 8'd65;
                    6'd44: v = 8'd78;
                    6'd60: v = 8'd0;
                    6'd61: v = 8'd1;
                    6'd62: v = 8'd32;
                    6'd63: v = 8'd1;
                    default: v = (a < 6'd18) ? m_regs[a[4:0]] : 8'h00;
                endcase
                r = {8'h00, v};
            end
            2'b10: begin
                if (a < 6'd18) m_regs[a[4:0]] = c[7:0];
                r = {8'hFF, c[7:0]};
            end
            2'b00: begin
`ifdef RHD_RESP_CONVERT_PATTERN_EN
                r = {a, m_conv};
                m_conv = m_conv + 10'd1;
`else
                r = 16'h8000;
`endif
            end
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    // driver: one SPI frame of nbits, MISO sampled just before each SCLK rise
    task automatic drive_frame(input logic [15:0] c, input int nbits, output logic [15:0] got);
        got = '0;
        rhd_cs = 1'b0;
        #H;
        for (int i = 0; i < nbits; i++) begin
            rhd_mosi = c[15-i];
            #H;
            got[15-i] = rhd_miso;
            rhd_sck = 1'b1;
            #H;
            rhd_sck = 1'b0;
        end
        rhd_mosi = 1'b0;
        #H;
        rhd_cs = 1'b1;
        #(2*H);
    endtask

    task automatic send(input logic [15:0] c, output logic [15:0] got, output logic [15:0] exp);
        exp_q.push_back(model_resp(c));
        drive_frame(c, 16, got);
        exp = exp_q.pop_front();
        n_valid++;
    endtask

    task automatic do_reset();
        rst = 1'b1; rhd_cs = 1'b1; rhd_sck = 1'b0; rhd_mosi = 1'b0;
        repeat (4) @(negedge sysclk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge sysclk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rhd_miso !== 1'b0)      begin failures++; $display("FAIL reset_miso got=%b exp=0", rhd_miso); end
        checks++; if (frame_done !== 1'b0)    begin failures++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        checks++; if (frame_err !== 1'b0)     begin failures++; $display("FAIL reset_err got=%b exp=0", frame_err); end
        checks++; if (last_cmd !== 16'h0000)  begin failures++; $display("FAIL reset_last_cmd got=%h exp=0000", last_cmd); end
    endtask

    task automatic test_rom_read();
        logic [15:0] cmds [3];
        logic [15:0] got [3];
        logic [15:0] exp;
        int base;
        cmds = '{16'hEA00, 16'hFF00, 16'hFF00};
        base = done_cnt;
        for (int i = 0; i < 3; i++) begin
            send(cmds[i], got[i], exp);
            checks++; if (got[i] !== exp) begin failures++; $display("FAIL rom_read_f%0d got=%h exp=%h", i, got[i], exp); end
        end
        checks++; if (got[0] !== 16'h0000 || got[1] !== 16'h0000) begin failures++; $display("FAIL rom_read_first_two got=%h,%h exp=0000,0000", got[0], got[1]); end
        checks++; if (got[2] !== 16'h0054) begin failures++; $display("FAIL rom_read_intan_t got=%h exp=0054", got[2]); end
        checks++; if (last_cmd !== 16'hFF00) begin failures++; $display("FAIL rom_read_last_cmd got=%h exp=ff00", last_cmd); end
        checks++; if (done_cnt - base != 3) begin failures++; $display("FAIL rom_read_done_pulses got=%0d exp=3", done_cnt - base); end
    endtask

    task automatic test_write_read();
        logic [15:0] cmds [4];
        logic [15:0] got [4];
        logic [15:0] exp;
        cmds = '{16'h80FE, 16'hC000, 16'hFF00, 16'hFF00};
        for (int i = 0; i < 4; i++) begin
            send(cmds[i], got[i], exp);
            checks++; if (got[i] !== exp) begin failures++; $display("FAIL write_read_f%0d got=%h exp=%h", i, got[i], exp); end
        end
        checks++; if (got[2] !== 16'hFFFE) begin failures++; $display("FAIL write_echo got=%h exp=fffe", got[2]); end
        checks++; if (got[3] !== 16'h00FE) begin failures++; $display("FAIL write_readback got=%h exp=00fe", got[3]); end
    endtask

    task automatic test_rom_protect();
        logic [15:0] cmds [8];
        logic [15:0] got [8];
        logic [15:0] exp;
        cmds = '{16'hA855, 16'hE800, 16'h92AA, 16'hD200, 16'h9133, 16'hD100, 16'hFF00, 16'hFF00};
        for (int i = 0; i < 8; i++) begin
            send(cmds[i], got[i], exp);
            checks++; if (got[i] !== exp) begin failures++; $display("FAIL rom_protect_f%0d got=%h exp=%h", i, got[i], exp); end
        end
        checks++; if (got[3] !== 16'h0049) begin failures++; $display("FAIL rom_write_ignored got=%h exp=0049", got[3]); end
        checks++; if (got[5] !== 16'h0000) begin failures++; $display("FAIL reg18_write_ignored got=%h exp=0000", got[5]); end
        checks++; if (got[7] !== 16'h0033) begin failures++; $display("FAIL reg17_writable got=%h exp=0033", got[7]); end
    endtask

    task automatic test_short_frame();
        logic [15:0] got, exp, lc;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt; lc = last_cmd;
        drive_frame(16'hC000, 12, got);
        checks++; if (err_cnt - e0 != 1)  begin failures++; $display("FAIL short_err_pulse got=%0d exp=1", err_cnt - e0); end
        checks++; if (done_cnt != d0)     begin failures++; $display("FAIL short_no_done got=%0d exp=0", done_cnt - d0); end
        checks++; if (last_cmd !== lc)    begin failures++; $display("FAIL short_last_cmd got=%h exp=%h", last_cmd, lc); end
        send(16'hFF00, got, exp);
        checks++; if (got !== exp)        begin failures++; $display("FAIL short_pipeline_kept got=%h exp=%h", got, exp); end
    endtask

    task automatic test_convert();
        logic [15:0] cmds [7];
        logic [15:0] got [7];
        logic [15:0] exp;
        logic [15:0] conv_exp [3];
`ifdef RHD_RESP_CONVERT_PATTERN_EN
        conv_exp = '{16'h1400, 16'h1401, 16'h1402};
`else
        conv_exp = '{16'h8000, 16'h8000, 16'h8000};
`endif
        cmds = '{16'h0500, 16'h0500, 16'h0500, CMD_CALIBRATE, CMD_CLEAR, 16'h4123, 16'hFF00};
        for (int i = 0; i < 7; i++) begin
            send(cmds[i], got[i], exp);
            checks++; if (got[i] !== exp) begin failures++; $display("FAIL convert_f%0d got=%h exp=%h", i, got[i], exp); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (got[i+2] !== conv_exp[i]) begin failures++; $display("FAIL convert_resp%0d got=%h exp=%h", i, got[i+2], conv_exp[i]); end
        end
        checks++; if (got[5] !== 16'h0000 || got[6] !== 16'h0000) begin failures++; $display("FAIL calib_clear_resp got=%h,%h exp=0000,0000", got[5], got[6]); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] got, exp;
        logic [15:0] cmds [4];
        logic [15:0] outs [4];
        int d0, e0;
        send(16'h8180, got, exp);
        send(16'h8180, got, exp);
        checks++; if (got !== exp) begin failures++; $display("FAIL midrst_setup got=%h exp=%h", got, exp); end
        d0 = done_cnt; e0 = err_cnt;
        rhd_cs = 1'b0;
        #H;
        for (int i = 0; i < 8; i++) begin
            rhd_mosi = 1'b1; #H; rhd_sck = 1'b1; #H; rhd_sck = 1'b0;
        end
        #H;
        checks++; if (rhd_miso !== 1'b1) begin failures++; $display("FAIL midrst_pre_bit got=%b exp=1", rhd_miso); end
        rst = 1'b1;
        #1;
        checks++; if (rhd_miso !== 1'b0) begin failures++; $display("FAIL midrst_miso got=%b exp=0", rhd_miso); end
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            rhd_mosi = 1'b1; #H; rhd_sck = 1'b1; #H; rhd_sck = 1'b0;
        end
        #H; rhd_cs = 1'b1; #(2*H);
        checks++; if (err_cnt != e0 || done_cnt != d0) begin failures++; $display("FAIL midrst_no_pulse got=err%0d/done%0d exp=0/0", err_cnt - e0, done_cnt - d0); end
        checks++; if (last_cmd !== 16'h0000) begin failures++; $display("FAIL midrst_last_cmd got=%h exp=0000", last_cmd); end
        cmds = '{16'hEA00, 16'hC100, 16'hFF00, 16'hFF00};
        for (int i = 0; i < 4; i++) begin
            send(cmds[i], outs[i], exp);
            checks++; if (outs[i] !== exp) begin failures++; $display("FAIL midrst_f%0d got=%h exp=%h", i, outs[i], exp); end
        end
        checks++; if (outs[2] !== 16'h0054) begin failures++; $display("FAIL midrst_decode got=%h exp=0054", outs[2]); end
        checks++; if (outs[3] !== 16'h0000) begin failures++; $display("FAIL midrst_regs_cleared got=%h exp=0000", outs[3]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] c, got, exp;
        for (int n = 0; n < 30; n++) begin
            c = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 8'($urandom_range(0, 255))};
            send(c, got, exp);
            checks++; if (got !== exp)    begin failures++; $display("FAIL b2b_resp%0d cmd=%h got=%h exp=%h", n, c, got, exp); end
            checks++; if (last_cmd !== c) begin failures++; $display("FAIL b2b_last_cmd%0d got=%h exp=%h", n, last_cmd, c); end
        end
    endtask

    initial begin
        test_reset();
        n_valid = 0; done_cnt = 0; err_cnt = 0;
        test_rom_read();
        test_write_read();
        test_rom_protect();
        test_short_frame();
        test_convert();
        test_reset_mid_frame();
        test_back_to_back();
        checks++; if (done_cnt != n_valid) begin failures++; $display("FAIL total_done got=%0d exp=%0d", done_cnt, n_valid); end
        checks++; if (err_cnt != 1)        begin failures++; $display("FAIL total_err got=%0d exp=1", err_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
